reg_file_read: RTL and testbench
================================

Name: reg_file_read

Overview:
- Register file for the 16-bit custom RISC core, built around its read side: one write port, two read ports.
- Reads are registered, with a valid/ready output handshake so the decode stage can stall while read data is held.
- Same-cycle write-to-read bypass means the consumer never sees stale operands.
- Sits between writeback (producer of writes) and decode/execute (consumer of operand pairs).

Parameters:
- size, 16, data width of each register and each read port
- nregs, 8, number of architectural registers
- aw, 3, address width; must satisfy 2**aw >= nregs

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; clock is clk, reset is rst, active-low asynchronous
- wr_en  input  1  write strobe
- wr_addr  input  aw  write register index
- wr_data  input  size  write data
- rd_req  input  1  read request; operand pair addresses valid
- rd_addr_a  input  aw  port A register index
- rd_addr_b  input  aw  port B register index
- rd_ready  input  1  consumer accepts the held read result
- rd_accept  output  1  combinational; request accepted this cycle
- rd_valid  output  1  rd_data_a/rd_data_b hold a valid result
- rd_data_a  output  size  port A read result
- rd_data_b  output  size  port B read result

Behaviour:
- Reset (rst low, asynchronous):
  - all nregs registers cleared to 0;
  - rd_valid=0, rd_data_a=0, rd_data_b=0.
  - Effect is immediate, mid-transaction included; any held result is discarded.
- Write: on posedge, if wr_en=1 and wr_addr<nregs, then reg[wr_addr] <= wr_data.
  - wr_addr >= nregs is ignored, with no side effects.
- Accept rule: rd_accept = rd_req & (~rd_valid | rd_ready).
- Output register, on posedge:
  - if rd_accept: rd_valid<=1 and data registers load. Latency is 1 cycle from acceptance to rd_valid.
  - else if rd_ready: rd_valid<=0 and data registers keep their last value.
  - else: data and rd_valid are held unchanged (stall).
- Back-to-back: rd_req=1 and rd_ready=1 every cycle gives one result per cycle, with no bubble.
- Bypass: on an accepted read with wr_en=1 and wr_addr==rd_addr_x (x=a or b), port x loads wr_data rather than the old array contents.
  - Both ports may bypass in the same cycle.
- Held result is a snapshot: a write to an address whose data is currently held with rd_valid=1 does NOT alter rd_data_a/rd_data_b.
- Out-of-range read address (>= nregs) returns 0.
- rd_addr_a == rd_addr_b is legal; both ports return the same value.
- Inputs are sampled only in the accept cycle. Addresses in non-accept cycles are don't-care.

Optional Feature:
- Macro: REG_ZERO_EN.
- Defined:
  - register 0 is hardwired to 0;
  - writes to address 0 are dropped;
  - reads of address 0 return 0, including the bypass case with wr_addr=0.
- Undefined: register 0 is an ordinary read/write register.

Decomposition:
- Shared package customrisc_pkg holds:
  - constants DATA_W=16, NREGS=8, REG_AW=3;
  - localparam REG_ZERO=0.
  - reg_file_read parameter defaults take their values from these.
- One sub-module, reg_bank: the storage array plus write decode, exposing two combinational read ports.
- reg_file_read owns the bypass muxes, the handshake and the output registers.

Test Plan:
- Reset value: assert rst=0 mid-stall with rd_valid=1 -> rd_valid=0 and rd_data_a=rd_data_b=0 immediately. After release, a read of r1,r2 returns 0,0.
- Basic read: write r3=16'hBEEF, then rd_req with a=3, b=3, rd_ready=1 -> next cycle rd_valid=1, rd_data_a=rd_data_b=16'hBEEF.
- Bypass: same cycle wr_en=1, wr_addr=5, wr_data=16'h1234, rd_req a=5 b=4 (r4=16'h0042) -> next cycle rd_data_a=16'h1234, rd_data_b=16'h0042.
- Stall/snapshot: read r2=16'h00AA, rd_ready=0 for 3 cycles, write r2=16'h00BB during the stall -> rd_data_a stays 16'h00AA and rd_accept=0. Raise rd_ready -> new request accepted that same cycle, returning 16'h00BB.
- Throughput: rd_req=1 and rd_ready=1 for 8 cycles, reading r0..r7 pre-loaded with i*16'h0101 -> 8 consecutive valid results, in order, with no gaps.
- REG_ZERO_EN: defined, write r0=16'hFFFF with a same-cycle read of r0 -> returns 0. Undefined, same stimulus -> returns 16'hFFFF.

Source files
------------

// File: rtl/customrisc_pkg.sv
// customrisc_pkg: shared register-file constants; REG_ZERO_EN hardwires register REG_ZERO to 0.
package customrisc_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS = 8;
  localparam int REG_AW = 3;
  localparam int REG_ZERO = 0;
`ifdef REG_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
endpackage

// File: rtl/reg_bank.sv
// reg_bank: register storage with write decode and two combinational read ports (REG_ZERO_EN via customrisc_pkg).
module reg_bank
  import customrisc_pkg::*;
#(
  parameter int size = DATA_W,
  parameter int nregs = NREGS,
  parameter int aw = REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [aw-1:0]   wr_addr,
  input  logic [size-1:0] wr_data,
  input  logic [aw-1:0]   addr_a,
  input  logic [aw-1:0]   addr_b,
  output logic [size-1:0] data_a,
  output logic [size-1:0] data_b
);
  logic [size-1:0] regs [nregs];
  logic            we;
  assign we = wr_en && int'(wr_addr) < nregs && !(ZERO_EN && int'(wr_addr) == REG_ZERO);
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < nregs; i++) regs[i] <= '0;
    else if (we) regs[wr_addr] <= wr_data;
  assign data_a = int'(addr_a) < nregs ? regs[addr_a] : '0;
  assign data_b = int'(addr_b) < nregs ? regs[addr_b] : '0;
endmodule

// File: rtl/reg_file_read.sv
// reg_file_read: register file with registered, bypassed dual reads and valid/ready output handshake.
// REG_ZERO_EN (customrisc_pkg) makes register 0 read as zero, bypass included.
module reg_file_read
  import customrisc_pkg::*;
#(
  parameter int size = DATA_W,
  parameter int nregs = NREGS,
  parameter int aw = REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [aw-1:0]   wr_addr,
  input  logic [size-1:0] wr_data,
  input  logic            rd_req,
  input  logic [aw-1:0]   rd_addr_a,
  input  logic [aw-1:0]   rd_addr_b,
  input  logic            rd_ready,
  output logic            rd_accept,
  output logic            rd_valid,
  output logic [size-1:0] rd_data_a,
  output logic [size-1:0] rd_data_b
);
  logic [size-1:0] bank_a, bank_b, next_a, next_b;
  logic            wr_live;
  reg_bank #(.size(size), .nregs(nregs), .aw(aw)) u_bank (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .addr_a(rd_addr_a), .addr_b(rd_addr_b), .data_a(bank_a), .data_b(bank_b)
  );
  // only writes that will actually land in the array may be forwarded
  assign wr_live = wr_en && int'(wr_addr) < nregs && !(ZERO_EN && int'(wr_addr) == REG_ZERO);
  assign next_a = wr_live && wr_addr == rd_addr_a ? wr_data : bank_a;
  assign next_b = wr_live && wr_addr == rd_addr_b ? wr_data : bank_b;
  assign rd_accept = rd_req & (~rd_valid | rd_ready);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      rd_data_a <= next_a;
      rd_data_b <= next_b;
    end else if (rd_ready) rd_valid <= 1'b0;
endmodule

// File: tb/tb_reg_file_read.sv
// tb_reg_file_read: directed bench with a behavioural register-file model checked every cycle.
module tb_reg_file_read;
  logic        clk = 0, rst = 0;
  logic        wr_en = 0, rd_req = 0, rd_ready = 0;
  logic [2:0]  wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [15:0] wr_data = 0;
  logic        rd_accept, rd_valid;
  logic [15:0] rd_data_a, rd_data_b;
  int          checks = 0, failures = 0;
`ifdef REG_ZERO_EN
  localparam bit zero = 1'b1;
`else
  localparam bit zero = 1'b0;
`endif

  reg_file_read dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ready(rd_ready),
    .rd_accept(rd_accept), .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  // model: architectural contents plus the currently presented result
  logic [15:0] m_regs [8];
  logic        m_valid;
  logic [15:0] m_a, m_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_valid = 0; m_a = 0; m_b = 0;
    end else begin
      logic        wok;
      logic [15:0] after [8];
      wok = wr_en && !(zero && wr_addr == 0);
      after = m_regs;
      if (wok) after[wr_addr] = wr_data;
      if (rd_req && (!m_valid || rd_ready)) begin
        m_a = after[rd_addr_a];
        m_b = after[rd_addr_b];
        m_valid = 1;
      end else if (rd_ready) m_valid = 0;
      m_regs = after;
    end
  end

  always @(negedge clk) if (rst) begin
    chk("model_accept", rd_accept, rd_req && (!m_valid || rd_ready));
    chk("model_valid", rd_valid, m_valid);
    chk("model_data_a", rd_data_a, m_a);
    chk("model_data_b", rd_data_b, m_b);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    rd_req = 1; rd_addr_a = a; rd_addr_b = b; rd_ready = 1;
    tick;
    rd_req = 0;
  endtask

  initial begin
    tick; tick;
    rst = 1;
    tick;
    chk("reset_valid", rd_valid, 0);
    // mid-stall asynchronous reset discards the held result
    wr(1, 16'h0005);
    rd(1, 1);
    rd_ready = 0; rd_req = 1;
    tick;
    chk("stall_before_reset", rd_data_a, 16'h0005);
    #2 rst = 0;
    #1;
    chk("async_reset_valid", rd_valid, 0);
    chk("async_reset_data", {rd_data_a, rd_data_b}, 0);
    rd_req = 0;
    #2 rst = 1;
    rd(1, 2);
    chk("post_reset_read", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 32'h0});
    // basic read
    wr(3, 16'hBEEF);
    rd(3, 3);
    chk("basic_read", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 16'hBEEF, 16'hBEEF});
    // bypass
    wr(4, 16'h0042);
    wr_en = 1; wr_addr = 5; wr_data = 16'h1234;
    rd(5, 4);
    wr_en = 0;
    chk("bypass", {rd_data_a, rd_data_b}, {16'h1234, 16'h0042});
    // both ports bypass
    wr_en = 1; wr_addr = 6; wr_data = 16'h7777;
    rd(6, 6);
    wr_en = 0;
    chk("bypass_both", {rd_data_a, rd_data_b}, {16'h7777, 16'h7777});
    // stall with snapshot
    wr(2, 16'h00AA);
    rd(2, 2);
    rd_req = 1; rd_ready = 0; rd_addr_a = 2; rd_addr_b = 2;
    wr_en = 1; wr_addr = 2; wr_data = 16'h00BB;
    #1 chk("stall_accept", rd_accept, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      wr_en = 0;
      chk("stall_hold", {rd_valid, rd_data_a}, {1'b1, 16'h00AA});
    end
    rd_ready = 1;
    #1 chk("release_accept", rd_accept, 1);
    tick;
    chk("release_data", rd_data_a, 16'h00BB);
    rd_req = 0;
    tick;
    chk("drain_valid", rd_valid, 0);
    // throughput
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i) * 16'h0101);
    rd_req = 1; rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      tick;
      chk("stream_a", {rd_valid, rd_data_a}, {1'b1, (zero && i == 0) ? 16'h0 : 16'(i) * 16'h0101});
    end
    rd_req = 0;
    tick;
    chk("stream_end", rd_valid, 0);
    // register 0 write with same-cycle read
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF;
    rd(0, 0);
    wr_en = 0;
    chk("reg0_bypass", rd_data_a, zero ? 16'h0 : 16'hFFFF);
    rd(0, 1);
    chk("reg0_read", rd_data_a, zero ? 16'h0 : 16'hFFFF);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
